// File: rtl/race_pkg.sv
// Shared definitions for the race controller: state codes, winner codes and
// the default race-timer saturation value.
package race_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_DONE      = 3'd3
  } state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_TIE  = 2'b11;

  localparam logic [7:0] TIME_MAX_DEFAULT = 8'd255;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-player round-robin arbiter for the shared pixel-plot port. A grant is
// held until the grantee reports its burst done.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       active,
  output logic [1:0] grant
);

  logic       last_p2;
  logic       last_p2_next;
  logic [1:0] grant_next;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant   <= 2'b00;
      last_p2 <= 1'b1;
    end else begin
      grant   <= grant_next;
      last_p2 <= last_p2_next;
    end
  end

  // New grants are only issued from a free port, so a done pulse always
  // leaves at least one idle cycle before the next burst.
  always_comb begin
    grant_next   = grant;
    last_p2_next = last_p2;
    if (!active) begin
      grant_next = 2'b00;
    end else if (grant == 2'b00) begin
      if (req[0] && (!req[1] || last_p2)) begin
        grant_next   = 2'b01;
        last_p2_next = 1'b0;
      end else if (req[1]) begin
        grant_next   = 2'b10;
        last_p2_next = 1'b1;
      end
    end else if (done) begin
      grant_next = 2'b00;
    end
  end

endmodule

// File: rtl/race_controller.sv
// Race game controller: countdown, timed run with finish detection, and
// arbitration of the shared plot port between the two players.
module race_controller
  import race_pkg::*;
#(
  parameter int         COUNT_TICKS = 3,
  parameter logic [7:0] TIME_MAX    = TIME_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] finish,
  input  logic [1:0] draw_req,
  input  logic       draw_done,
  output logic       enable,
  output logic       p_reset,
  output logic [1:0] grant,
  output logic [7:0] race_time,
  output logic [1:0] winner,
  output logic [2:0] state_out
);

  localparam int CD_W = (COUNT_TICKS < 2) ? 1 : $clog2(COUNT_TICKS + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COUNT_TICKS);

  state_t          state, state_next;
  logic [CD_W-1:0] cd, cd_next;
  logic [7:0]      time_next;
  logic [1:0]      winner_next;
  logic            arb_active;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cd        <= '0;
      race_time <= 8'd0;
      winner    <= W_NONE;
      enable    <= 1'b0;
      p_reset   <= 1'b1;
    end else begin
      state     <= state_next;
      cd        <= cd_next;
      race_time <= time_next;
      winner    <= winner_next;
      enable    <= (state_next == S_RUN);
      p_reset   <= (state_next == S_IDLE);
    end
  end

  // Dropping start aborts from anywhere; race_time and winner are kept for
  // display until the next countdown begins.
  always_comb begin
    state_next  = state;
    cd_next     = cd;
    time_next   = race_time;
    winner_next = winner;
    if (!start) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_next  = S_COUNTDOWN;
          cd_next     = CD_LOAD;
          time_next   = 8'd0;
          winner_next = W_NONE;
        end
        S_COUNTDOWN: begin
          if (tick) begin
            cd_next = cd - 1'b1;
            if (cd == CD_W'(1)) state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (tick && race_time != TIME_MAX) time_next = race_time + 8'd1;
          if (finish != 2'b00) begin
            state_next  = S_DONE;
            winner_next = finish;
          end else if (tick && race_time == TIME_MAX - 8'd1) begin
            state_next  = S_DONE;
            winner_next = W_NONE;
          end
        end
        S_DONE: ;
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign state_out  = state;
  assign arb_active = (state != S_IDLE) && start;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (draw_req),
    .done   (draw_done),
    .active (arb_active),
    .grant  (grant)
  );

endmodule

// File: tb/tb_race_controller.sv
// Directed self-checking bench for race_controller; a second instance with a
// short timer exercises timeout saturation alongside the default instance.
module tb_race_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       tick;
  logic [1:0] finish;
  logic [1:0] draw_req;
  logic       draw_done;

  logic       enable_a, p_reset_a, enable_b, p_reset_b;
  logic [1:0] grant_a, winner_a, grant_b, winner_b;
  logic [7:0] race_time_a, race_time_b;
  logic [2:0] state_a, state_b;

  int checks   = 0;
  int failures = 0;

  race_controller u_dut_a (
    .clk(clk), .resetn(resetn), .start(start), .tick(tick), .finish(finish),
    .draw_req(draw_req), .draw_done(draw_done), .enable(enable_a),
    .p_reset(p_reset_a), .grant(grant_a), .race_time(race_time_a),
    .winner(winner_a), .state_out(state_a)
  );

  race_controller #(.COUNT_TICKS(3), .TIME_MAX(8'd4)) u_dut_b (
    .clk(clk), .resetn(resetn), .start(start), .tick(tick), .finish(finish),
    .draw_req(draw_req), .draw_done(draw_done), .enable(enable_b),
    .p_reset(p_reset_b), .grant(grant_b), .race_time(race_time_b),
    .winner(winner_b), .state_out(state_b)
  );

  always #5 clk = ~clk;

  // One clock with the given pulses; pulses drop right after the edge.
  task automatic applyStimulus(input logic t, input logic [1:0] f, input logic dd);
    tick      = t;
    finish    = f;
    draw_done = dd;
    @(posedge clk);
    #1;
    tick      = 1'b0;
    finish    = 2'b00;
    draw_done = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; draw_req = 2'b11;
    applyStimulus(1'b1, 2'b11, 1'b1);
    checkOutput("rst_state", 8'(state_a), 8'd0);
    checkOutput("rst_enable", 8'(enable_a), 8'd0);
    checkOutput("rst_preset", 8'(p_reset_a), 8'd1);
    checkOutput("rst_grant", 8'(grant_a), 8'd0);
    checkOutput("rst_time", race_time_a, 8'd0);
    checkOutput("rst_winner", 8'(winner_a), 8'd0);

    $display("[TB] countdown and run");
    resetn = 1'b1; draw_req = 2'b00;
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("cd_state", 8'(state_a), 8'd1);
    checkOutput("cd_preset", 8'(p_reset_a), 8'd0);
    checkOutput("cd_enable", 8'(enable_a), 8'd0);
    applyStimulus(1'b1, 2'b00, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("cd_state_2ticks", 8'(state_a), 8'd1);
    applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("run_state", 8'(state_a), 8'd2);
    checkOutput("run_enable", 8'(enable_a), 8'd1);
    checkOutput("run_time0", race_time_a, 8'd0);

    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("b_time3", race_time_b, 8'd3);
    checkOutput("b_state_run", 8'(state_b), 8'd2);
    applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("b_timeout_time", race_time_b, 8'd4);
    checkOutput("b_timeout_state", 8'(state_b), 8'd3);
    checkOutput("b_timeout_winner", 8'(winner_b), 8'd0);
    checkOutput("b_timeout_enable", 8'(enable_b), 8'd0);
    applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("a_time5", race_time_a, 8'd5);
    checkOutput("b_time_frozen", race_time_b, 8'd4);

    applyStimulus(1'b0, 2'b01, 1'b0);
    checkOutput("p1_state", 8'(state_a), 8'd3);
    checkOutput("p1_winner", 8'(winner_a), 8'd1);
    checkOutput("p1_enable", 8'(enable_a), 8'd0);
    checkOutput("p1_time", race_time_a, 8'd5);
    applyStimulus(1'b1, 2'b10, 1'b0);
    checkOutput("done_time_frozen", race_time_a, 8'd5);
    checkOutput("done_winner_frozen", 8'(winner_a), 8'd1);

    start = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("abort_state", 8'(state_a), 8'd0);
    checkOutput("abort_preset", 8'(p_reset_a), 8'd1);
    checkOutput("abort_time_kept", race_time_a, 8'd5);
    checkOutput("abort_winner_kept", 8'(winner_a), 8'd1);

    $display("[TB] tie on the timeout tick");
    start = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("restart_time", race_time_a, 8'd0);
    checkOutput("restart_winner", 8'(winner_a), 8'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("b_time3_again", race_time_b, 8'd3);
    applyStimulus(1'b1, 2'b11, 1'b0);
    checkOutput("tie_winner_a", 8'(winner_a), 8'd3);
    checkOutput("tie_state_a", 8'(state_a), 8'd3);
    checkOutput("tie_time_a", race_time_a, 8'd4);
    checkOutput("tie_winner_b", 8'(winner_b), 8'd3);
    checkOutput("tie_time_b", race_time_b, 8'd4);

    $display("[TB] arbiter");
    start = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0);
    draw_req = 2'b11;
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("idle_no_grant", 8'(grant_a), 8'd0);
    start = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("entry_no_grant", 8'(grant_a), 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("grant_p1_first", 8'(grant_a), 8'd1);
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("grant_p1_hold", 8'(grant_a), 8'd1);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("grant_free1", 8'(grant_a), 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("grant_p2", 8'(grant_a), 8'd2);
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("grant_p2_hold", 8'(grant_a), 8'd2);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("grant_free2", 8'(grant_a), 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("grant_p1_again", 8'(grant_a), 8'd1);

    draw_req = 2'b00;
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("grant_kept_no_req", 8'(grant_a), 8'd1);
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("grant_free3", 8'(grant_a), 8'd0);
    draw_req = 2'b10;
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkOutput("stray_done_ignored", 8'(grant_a), 8'd2);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b00, 1'b0);
    checkOutput("run_with_grant_state", 8'(state_a), 8'd2);
    checkOutput("run_with_grant_time", race_time_a, 8'd2);
    checkOutput("run_with_grant_grant", 8'(grant_a), 8'd2);
    start = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("kill_state", 8'(state_a), 8'd0);
    checkOutput("kill_grant", 8'(grant_a), 8'd0);
    checkOutput("kill_preset", 8'(p_reset_a), 8'd1);
    checkOutput("kill_time_kept", race_time_a, 8'd2);
    checkOutput("kill_winner_kept", 8'(winner_a), 8'd0);
    applyStimulus(1'b0, 2'b00, 1'b0);
    checkOutput("idle_grant_stays_free", 8'(grant_a), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/race_controller.md
RACE_CONTROLLER -- requirements
Module: race_controller

Interface
REQ-001 Parameter COUNT_TICKS, default 3: number of tick pulses spent in COUNTDOWN.
REQ-002 Parameter TIME_MAX, default 8'd255: race timer saturation value.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  game enable level (switch); high = play, low = abort/idle.
REQ-006 tick  input  1  one-cycle time-base pulse.
REQ-007 finish  input  2  bit i high = player i+1 reached the top.
REQ-008 draw_req  input  2  bit i high = player i+1 requests the shared pixel-plot port.
REQ-009 draw_done  input  1  one-cycle pulse from the current grantee: plot burst complete.
REQ-010 enable  output  1  players may advance.
REQ-011 p_reset  output  1  clears player datapaths.
REQ-012 grant  output  2  one-hot plot-port grant; 2'b00 = port free.
REQ-013 race_time  output  8  elapsed RUN ticks.
REQ-014 winner  output  2  00 none/timeout, 01 P1, 10 P2, 11 tie.
REQ-015 state_out  output  3  current state code, for debug/HEX display.

Function
REQ-016 States: IDLE=0, COUNTDOWN=1, RUN=2, DONE=3; all outputs registered.
REQ-017 start low in any state: next state IDLE; this has priority over every other transition.
REQ-018 IDLE: p_reset=1, enable=0, grant=00, draw_req ignored; start high -> COUNTDOWN, load cd=COUNT_TICKS, race_time=0, winner=00.
REQ-019 COUNTDOWN: cd decrements on tick; tick while cd==1 -> RUN; p_reset=0, enable=0.
REQ-020 RUN: enable=1; race_time increments on each tick, saturating at TIME_MAX.
REQ-021 RUN, any finish bit high: -> DONE; winner = finish[1:0] as sampled (both bits high = 11 tie).
REQ-022 RUN, tick with race_time==TIME_MAX-1: race_time=TIME_MAX, -> DONE, winner=00; a finish bit in the same cycle takes priority and sets winner per REQ-021.
REQ-023 DONE: enable=0, race_time and winner frozen; exits only via start low (REQ-017).
REQ-024 Arbiter is active in COUNTDOWN, RUN and DONE; in DONE it keeps granting so final boxes are drawn.
REQ-025 Grant only when grant==00; a request in cycle n yields grant at edge n+1.
REQ-026 Both requesting: grant the player not served last; last_served resets to P2, so P1 wins the first tie.
REQ-027 Grant holds until draw_done; draw_done clears grant at that edge; next grant no earlier than the following edge (min one free cycle).
REQ-028 draw_done while grant==00 is ignored; a grantee dropping draw_req does not revoke grant.
REQ-029 Transition to IDLE clears grant at the same edge; an in-flight burst is abandoned.

Reset
REQ-030 resetn low at a clk edge: state=IDLE, cd=0, race_time=0, winner=00, grant=00, last_served=P2, enable=0, p_reset=1.
REQ-031 Reset overrides start, tick, finish and draw_done in the same cycle.

Structure
REQ-032 Shared package race_pkg holds the state codes, winner codes and the TIME_MAX default.
REQ-033 The arbiter is a single sub-module, rr_arbiter2 (req[1:0], done, active -> grant[1:0]).

Verification
REQ-034 Reset, start=1, COUNT_TICKS=3, three ticks -> state_out 0->1->2 after 3rd tick, enable=1, race_time=0.
REQ-035 RUN, 5 ticks, then finish=01 -> race_time=5, winner=01, state DONE, enable=0 next cycle.
REQ-036 RUN, finish=11 same cycle -> winner=11; with TIME_MAX=4, 4 ticks and no finish -> race_time=4, winner=00.
REQ-037 draw_req=11 continuously, draw_done 2 cycles after each grant -> grants alternate 01,00,10,00,01 starting with P1.
REQ-038 start low during RUN with grant=10 -> next edge state IDLE, grant=00, p_reset=1; race_time and winner retained until the next COUNTDOWN entry.
